event_recorder: RTL
===================

EVENT_RECORDER -- requirements
Module: event_recorder

Interface
REQ-001 Parameter DEPTH, default 8: record buffer depth; power of two, minimum 2.
REQ-002 Parameter WIDTH, default 8: event payload width in bits.
REQ-003 Parameter TS_WIDTH, default 16: timestamp width in bits.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 evt_valid  input  1  event present this cycle.
REQ-007 evt_level  input  3  severity: 0 TRACE, 1 DEBUG, 2 INFO, 3 WARN, 4 ERROR, 5 FATAL.
REQ-008 evt_data  input  WIDTH  event payload.
REQ-009 min_level  input  3  severity threshold; exists only when EVENT_RECORDER_LEVEL_FILTER_EN is defined.
REQ-010 rec_valid  output  1  head record available.
REQ-011 rec_ready  input  1  consumer accepts head record.
REQ-012 rec_ts  output  TS_WIDTH  head record timestamp.
REQ-013 rec_level  output  3  head record severity.
REQ-014 rec_data  output  WIDTH  head record payload.
REQ-015 count  output  $clog2(DEPTH)+1  records held.
REQ-016 full  output  1  count == DEPTH.
REQ-017 dropped  output  8  saturating count of events lost to overflow.

Function
REQ-018 Free-running timestamp counter SHALL increment by 1 every clk cycle and wrap from 2^TS_WIDTH-1 to 0.
REQ-019 Event accept SHALL occur at a rising edge with evt_valid=1 and buffer space available; the stored record is {timestamp value in that cycle, level, data}.
REQ-020 evt_level values 6 and 7 SHALL be stored as 2 (INFO).
REQ-021 Buffer SHALL be first-word-fall-through: rec_valid = (count != 0); rec_ts/rec_level/rec_data show the oldest record combinationally from registered storage.
REQ-022 Pop SHALL occur at a rising edge with rec_valid=1 and rec_ready=1; rec_* SHALL hold stable while rec_valid=1 and rec_ready=0.
REQ-023 Accept-to-output latency SHALL be one cycle: a record accepted into an empty buffer at edge k drives rec_valid=1 immediately after edge k.
REQ-024 Full with simultaneous pop: the incoming event SHALL be accepted; count stays DEPTH.
REQ-025 Full without pop: the incoming event SHALL be discarded and dropped SHALL increment, saturating at 255.
REQ-026 Empty with evt_valid=1 and rec_ready=1: no pop occurs (rec_valid=0); the event is accepted; count becomes 1.
REQ-027 Non-full, non-empty, simultaneous push and pop: count SHALL be unchanged.
REQ-028 Read/write pointers SHALL wrap modulo DEPTH; records SHALL leave in acceptance order.
REQ-029 rec_valid=1 SHALL never present an X or stale entry.

Reset
REQ-030 rst_n=0 SHALL asynchronously force timestamp=0, count=0, pointers=0, dropped=0, rec_valid=0, full=0; rec_ts/rec_level/rec_data SHALL read 0.
REQ-031 Records held at reset assertion SHALL be lost; the first event after release is stamped with the counter value of its cycle (0 on the first edge after release).
REQ-032 Storage contents need no reset; outputs SHALL be gated to 0 while empty.

Configuration
REQ-033 Macro EVENT_RECORDER_LEVEL_FILTER_EN defined: min_level port exists; events with evt_level (after REQ-020 mapping) < min_level SHALL be discarded without affecting count or dropped.
REQ-034 Macro undefined: min_level port absent; every valid event is subject only to REQ-019 and REQ-024/025.

Verification
REQ-035 Reset release, evt_valid=1 level=2 data=0xA5 at first edge, rec_ready=0 -> rec_valid=1, rec_ts=0, rec_level=2, rec_data=0xA5, count=1.
REQ-036 Push 8 events data=0..7 with rec_ready=0, then 3 more -> full=1, count=8, dropped=3; drain yields data 0..7 in order.
REQ-037 Full buffer, evt_valid=1 data=0x55 and rec_ready=1 same edge -> count=8, dropped unchanged, 0x55 appears as 8th record.
REQ-038 Push level=7 data=0x11 -> rec_level=2; 300 overflow events -> dropped=255.
REQ-039 Filter enabled, min_level=4, push levels 3,4,5 -> only levels 4 and 5 recorded, dropped=0; filter disabled, same stimulus -> all three recorded.
REQ-040 rst_n asserted mid-drain with count=5 -> rec_valid=0, count=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/event_recorder.sv
// Timestamped event recorder: a first-word-fall-through buffer of {timestamp, severity, payload}.
// Optional severity filter (min_level port) is enabled by defining EVENT_RECORDER_LEVEL_FILTER_EN.
module event_recorder #(
    parameter int DEPTH    = 8,
    parameter int WIDTH    = 8,
    parameter int TS_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     evt_valid,
    input  logic [2:0]               evt_level,
    input  logic [WIDTH-1:0]         evt_data,
`ifdef EVENT_RECORDER_LEVEL_FILTER_EN
    input  logic [2:0]               min_level,
`endif
    output logic                     rec_valid,
    input  logic                     rec_ready,
    output logic [TS_WIDTH-1:0]      rec_ts,
    output logic [2:0]               rec_level,
    output logic [WIDTH-1:0]         rec_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic [7:0]               dropped
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [TS_WIDTH-1:0] ts;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;

    logic [TS_WIDTH-1:0] mem_ts    [DEPTH];
    logic [2:0]          mem_level [DEPTH];
    logic [WIDTH-1:0]    mem_data  [DEPTH];

    logic [2:0] level_mapped;
    logic       level_pass;
    logic       pop;
    logic       push;
    logic       drop;

    // Undefined severities 6 and 7 are recorded as INFO; a pop frees a slot for a same-cycle push.
    always_comb begin
        level_mapped = (evt_level > 3'd5) ? 3'd2 : evt_level;
`ifdef EVENT_RECORDER_LEVEL_FILTER_EN
        level_pass   = (level_mapped >= min_level);
`else
        level_pass   = 1'b1;
`endif
        pop          = rec_valid && rec_ready;
        push         = evt_valid && level_pass && (!full || pop);
        drop         = evt_valid && level_pass && full && !pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts <= '0;
        end else begin
            ts <= ts + TS_WIDTH'(1);
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            dropped <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop && (dropped != 8'hFF)) begin
                dropped <= dropped + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_ts[wr_ptr]    <= ts;
            mem_level[wr_ptr] <= level_mapped;
            mem_data[wr_ptr]  <= evt_data;
        end
    end

    // Storage is never reset, so the head is gated to zero whenever nothing valid is held.
    always_comb begin
        full      = (count == FULL_COUNT);
        rec_valid = (count != '0);
        rec_ts    = rec_valid ? mem_ts[rd_ptr]    : '0;
        rec_level = rec_valid ? mem_level[rd_ptr] : '0;
        rec_data  = rec_valid ? mem_data[rd_ptr]  : '0;
    end

endmodule
